// File: rtl/occupancy_ram_arbiter.sv
// Two-port arbiter for the single-port occupancy-grid RAM: A has priority, B gets a bounded wait,
// and a one-cycle lock keeps A's read-modify-write atomic. Read data is routed back to its issuer.
module occupancy_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic                  lock_pending;
  logic [7:0]            wait_cnt;
  owner_t                read_owner;
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;
  logic                  wait_full;

  assign wait_full = (wait_cnt >= WAIT_LIMIT);

  // Grants are forced low while reset is held so the RAM never sees a stray enable.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (lock_pending && a_req)   a_gnt = 1'b1;
      else if (b_req && wait_full) b_gnt = 1'b1;
      else if (a_req)              a_gnt = 1'b1;
      else if (b_req)              b_gnt = 1'b1;
    end
  end

  always_comb begin
    ram_en    = a_gnt | b_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (a_gnt) begin
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (b_gnt) begin
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_pending <= 1'b0;
      wait_cnt     <= '0;
      read_owner   <= OWN_NONE;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      lock_pending <= a_gnt & a_lock;
      if (b_req && !b_gnt)
        wait_cnt <= wait_full ? WAIT_LIMIT : wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
      if (a_gnt && !a_we)      read_owner <= OWN_A;
      else if (b_gnt && !b_we) read_owner <= OWN_B;
      else                     read_owner <= OWN_NONE;
      // Capture the returned word so each port's rdata holds after its rvalid pulse.
      if (read_owner == OWN_A) a_rdata_q <= ram_rdata;
      if (read_owner == OWN_B) b_rdata_q <= ram_rdata;
    end
  end

  assign a_rvalid = (read_owner == OWN_A);
  assign b_rvalid = (read_owner == OWN_B);
  assign a_rdata  = a_rvalid ? ram_rdata : a_rdata_q;
  assign b_rdata  = b_rvalid ? ram_rdata : b_rdata_q;

endmodule

// File: tb/tb_occupancy_ram_arbiter.sv
// Directed bench for occupancy_ram_arbiter with a behavioural one-cycle-latency RAM.
module tb_occupancy_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        a_req, a_we, a_lock;
  logic [14:0] a_addr;
  logic [7:0]  a_wdata;
  logic        a_gnt, a_rvalid;
  logic [7:0]  a_rdata;
  logic        b_req, b_we;
  logic [14:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_gnt, b_rvalid;
  logic [7:0]  b_rdata;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:32767];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        a_req, a_we, a_lock;
    logic [14:0] a_addr;
    logic [7:0]  a_wdata;
    logic        b_req, b_we;
    logic [14:0] b_addr;
    logic [7:0]  b_wdata;
  } in_t;

  typedef struct packed {
    logic        a_gnt, b_gnt, ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        a_rvalid;
    logic [7:0]  a_rdata;
    logic        b_rvalid;
    logic [7:0]  b_rdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  out_t cur;
  assign cur = {a_gnt, b_gnt, ram_en, ram_we, ram_addr, ram_wdata,
                a_rvalid, a_rdata, b_rvalid, b_rdata};

  occupancy_ram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .MAX_WAIT(8)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    {a_req, a_we, a_lock, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata} = v;
  endtask

  task automatic set_a(input logic req, input logic we, input logic lk,
                       input logic [14:0] addr, input logic [7:0] wd);
    a_req = req; a_we = we; a_lock = lk; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [14:0] addr,
                       input logic [7:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  vec_t vecs [14];

  initial begin
    for (int k = 0; k < 32768; k++) mem[k] = 8'h00;
    mem[15'h0010] = 8'h11;
    mem[15'h0020] = 8'h22;
    mem[15'h0100] = 8'h33;
    ram_rdata = 8'h00;

    // in: a_req,a_we,a_lock,a_addr,a_wdata,b_req,b_we,b_addr,b_wdata
    // out: a_gnt,b_gnt,en,we,addr,wdata,a_rvalid,a_rdata,b_rvalid,b_rdata
    vecs[0]  = '{'{0,0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00}, '{0,0,0,0,15'h0000,8'h00, 0,8'h00, 0,8'h00}};
    vecs[1]  = '{'{0,0,0,15'h0000,8'h00, 1,1,15'h7FFF,8'h5A}, '{0,1,1,1,15'h7FFF,8'h5A, 0,8'h00, 0,8'h00}};
    vecs[2]  = '{'{0,0,0,15'h0000,8'h00, 1,0,15'h7FFF,8'h00}, '{0,1,1,0,15'h7FFF,8'h00, 0,8'h00, 0,8'h00}};
    vecs[3]  = '{'{0,0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00}, '{0,0,0,0,15'h0000,8'h00, 0,8'h00, 1,8'h5A}};
    vecs[4]  = '{'{0,0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00}, '{0,0,0,0,15'h0000,8'h00, 0,8'h00, 0,8'h5A}};
    vecs[5]  = '{'{1,0,0,15'h0010,8'h00, 1,0,15'h0020,8'h00}, '{1,0,1,0,15'h0010,8'h00, 0,8'h00, 0,8'h5A}};
    vecs[6]  = '{'{0,0,0,15'h0000,8'h00, 1,0,15'h0020,8'h00}, '{0,1,1,0,15'h0020,8'h00, 1,8'h11, 0,8'h5A}};
    vecs[7]  = '{'{1,0,0,15'h0100,8'h00, 0,0,15'h0000,8'h00}, '{1,0,1,0,15'h0100,8'h00, 0,8'h11, 1,8'h22}};
    vecs[8]  = '{'{0,0,0,15'h0000,8'h00, 1,0,15'h0010,8'h00}, '{0,1,1,0,15'h0010,8'h00, 1,8'h33, 0,8'h22}};
    vecs[9]  = '{'{0,0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00}, '{0,0,0,0,15'h0000,8'h00, 0,8'h33, 1,8'h11}};
    vecs[10] = '{'{1,0,1,15'h0020,8'h00, 0,0,15'h0000,8'h00}, '{1,0,1,0,15'h0020,8'h00, 0,8'h33, 0,8'h11}};
    vecs[11] = '{'{0,0,0,15'h0000,8'h00, 1,0,15'h0100,8'h00}, '{0,1,1,0,15'h0100,8'h00, 1,8'h22, 0,8'h11}};
    vecs[12] = '{'{1,0,0,15'h0010,8'h00, 1,0,15'h0020,8'h00}, '{1,0,1,0,15'h0010,8'h00, 0,8'h22, 1,8'h33}};
    vecs[13] = '{'{0,0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00}, '{0,0,0,0,15'h0000,8'h00, 1,8'h11, 0,8'h33}};

    reset = 1'b1;
    set_a(1, 0, 0, 15'h0010, 8'h00);
    set_b(1, 0, 15'h0020, 8'h00);
    #3;
    check("reset_state", 64'(cur), 64'h0);
    set_a(0, 0, 0, 15'h0000, 8'h00);
    set_b(0, 0, 15'h0000, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Single-port traffic, read routing and forfeited lock.
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      apply(vecs[i].i);
      #1;
      check($sformatf("vec%0d", i), 64'(cur), 64'(vecs[i].o));
    end

    // Both ports saturated: eight A grants then one B grant, repeating.
    for (int k = 0; k < 27; k++) begin
      @(negedge clock);
      set_a(1, 0, 0, 15'h0001, 8'h00);
      set_b(1, 0, 15'h0002, 8'h00);
      #1;
      check($sformatf("prio_k%0d", k), {62'h0, a_gnt, b_gnt},
            (k % 9 == 8) ? 64'h1 : 64'h2);
    end

    // Build wait_cnt up to 7, then a locked read-modify-write of 0x0100.
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      set_a(1, 0, 0, 15'h0001, 8'h00);
      set_b(1, 0, 15'h0002, 8'h00);
    end
    @(negedge clock);
    set_a(1, 0, 1, 15'h0100, 8'h00);
    #1;
    check("lock_read_gnt", {62'h0, a_gnt, b_gnt}, 64'h2);
    @(negedge clock);
    set_a(1, 1, 0, 15'h0100, 8'h77);
    #1;
    check("lock_write", {55'h0, a_gnt, b_gnt, ram_we, a_rvalid, a_rdata}, {55'h0, 4'b1011, 8'h33} );
    @(negedge clock);
    set_a(1, 0, 0, 15'h0100, 8'h00);
    #1;
    check("after_lock_b", {62'h0, a_gnt, b_gnt}, 64'h1);
    @(negedge clock);
    set_b(0, 0, 15'h0000, 8'h00);
    #1;
    check("reread_gnt", {62'h0, a_gnt, b_gnt}, 64'h2);
    @(negedge clock);
    set_a(0, 0, 0, 15'h0000, 8'h00);
    #1;
    check("rmw_result", {55'h0, a_rvalid, a_rdata}, {55'h0, 1'b1, 8'h77});

    // Reset between a read's accepting edge and its return.
    @(negedge clock);
    set_a(1, 0, 0, 15'h0010, 8'h00);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_read", 64'(cur), 64'h0);
    set_a(0, 0, 0, 15'h0000, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_reset_0", 64'(cur), 64'h0);
    @(negedge clock);
    #1;
    check("post_reset_1", 64'(cur), 64'h0);
    @(negedge clock);
    set_b(1, 0, 15'h0020, 8'h00);
    #1;
    check("post_reset_gnt", {48'h0, b_gnt, ram_en, ram_addr[13:0]}, {48'h0, 2'b11, 14'h0020});
    @(negedge clock);
    set_b(0, 0, 15'h0000, 8'h00);
    #1;
    check("post_reset_rd", {55'h0, b_rvalid, b_rdata}, {55'h0, 1'b1, 8'h22});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
